// File: rtl/clkbuf_branch_seq.sv
// Staggered enable sequencer for gated clock branches: walks EN toward a latched
// target mask one bit at a time, lowest index first, with STAGGER cycles between toggles.
module clkbuf_branch_seq #(
    parameter int unsigned NBR     = 4,
    parameter int unsigned STAGGER = 4,
    parameter int unsigned CW      = 8
) (
    input  logic           CLK,
    input  logic           RN,
    input  logic [NBR-1:0] REQ,
    input  logic           GO,
    input  logic           FORCE_OFF,
    output logic [NBR-1:0] EN,
    output logic           BUSY,
    output logic           DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT
    } state_t;

    // WAIT is entered one edge after the toggle and exits one edge early, hence S-2
    localparam logic [CW-1:0] RELOAD = (STAGGER > 1) ? CW'(STAGGER - 2) : '0;

    state_t         state_q;
    state_t         state_d;
    logic [NBR-1:0] tgt_q;
    logic [NBR-1:0] tgt_d;
    logic [NBR-1:0] en_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           busy_d;
    logic           done_d;
    logic [NBR-1:0] diff;
    logic [NBR-1:0] lowest;

    assign diff   = tgt_q ^ EN;
    // Isolates the lowest set bit of diff, i.e. the next branch to toggle
    assign lowest = diff & (~diff + NBR'(1));

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        en_d    = EN;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (FORCE_OFF) begin
            state_d = S_IDLE;
            tgt_d   = '0;
            en_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (GO) begin
                        tgt_d   = REQ;
                        state_d = S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (diff == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        en_d = EN ^ lowest;
                        if (STAGGER > 1) begin
                            cnt_d   = RELOAD;
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = S_APPLY;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            cnt_q   <= '0;
            EN      <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            EN      <= en_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
        end
    end

endmodule

// File: doc/clkbuf_branch_seq.md
Name: clkbuf_branch_seq

Overview:
- Sequences the enables of NBR gated clock branches, each driving a clkbuf tree, so that branches switch on or off one at a time.
- Consecutive branch toggles are spaced exactly STAGGER cycles apart, which limits supply di/dt when large clock trees wake or sleep.
- Sits between the power-management register block (target mask, GO) and the per-branch ICG enable pins.

Parameters:
- NBR, 4, number of clock branches (1..16).
- STAGGER, 4, CLK cycles between consecutive branch toggles (1..255).
- CW, 8, stagger counter width; must satisfy 2^CW > STAGGER.

Ports:
- CLK  input  1  sequencer clock (always-on domain, ungated).
- RN  input  1  reset, asynchronous, active-low.
- REQ  input  NBR  desired branch-enable mask; sampled only on an accepted GO.
- GO  input  1  single-cycle request to apply REQ.
- FORCE_OFF  input  1  emergency shutdown of all branches.
- EN  output  NBR  registered enables to the branch ICGs.
- BUSY  output  1  high while a sequence is in progress.
- DONE  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (RN=0, asynchronous): EN=0, BUSY=0, DONE=0, state=IDLE, target mask=0, counter=0. All outputs are registered.
- States: IDLE, APPLY, WAIT.
- IDLE:
  - GO=1 at edge k: latch tgt=REQ, go to APPLY, BUSY=1 after edge k.
  - GO while BUSY=1 is ignored; it is not queued and REQ is not re-latched.
- APPLY:
  - If tgt==EN: go to IDLE, BUSY=0, DONE=1 for exactly one cycle.
  - Otherwise, flip EN[i] for the lowest index i where tgt[i]!=EN[i]. Only one bit changes per edge; matching bits are skipped at zero cost.
  - After the flip: with STAGGER==1, stay in APPLY; otherwise load counter=STAGGER-2 and go to WAIT.
- WAIT: decrement the counter each edge; when it reads 0, go to APPLY on that edge.
- Timing: for m required toggles starting from GO at edge k:
  - toggles occur at edges k+1, k+1+S, ..., k+1+(m-1)S;
  - DONE is high in the cycle after edge k+1+mS when m>0;
  - DONE is high in the cycle after edge k+1 when m=0.
  - In the DONE cycle BUSY=0, and a GO is accepted in that same cycle.
- Ordering: strictly ascending index. Turn-ons and turn-offs are treated alike.
- FORCE_OFF=1 at any edge, in any state:
  - EN=0, tgt=0, state=IDLE, BUSY=0, DONE=0 on that edge;
  - it takes priority over GO in the same cycle;
  - no DONE pulse for the aborted sequence.
- FORCE_OFF held high: EN stays 0 and GO is ignored.
- RN asserted mid-sequence: immediate return to reset values. After release, EN stays 0 until a new GO.
- Counter never wraps: it is only decremented in WAIT with a value >0 and is reloaded on entry.
- The EN register holds its value in IDLE; REQ changes without GO have no effect.

Test Plan:
- Reset then GO with REQ=4'b1111, NBR=4, S=4, GO at edge 10:
  - EN steps 0001@11, 0011@15, 0111@19, 1111@23;
  - DONE high for one cycle after edge 27;
  - BUSY high from edge 10 until DONE.
- From EN=1111, GO with REQ=0101: EN=1101@k+1, then 0101@k+5, DONE after k+9. Exactly one bit changes per toggle.
- GO with REQ equal to EN=0110: no EN change, BUSY high for one cycle, DONE after edge k+1.
- S=1, REQ=1111 from 0: EN changes on 4 consecutive edges, DONE on the 5th cycle; a second GO mid-sequence is ignored.
- FORCE_OFF pulsed during WAIT after EN=0011: EN=0000 on that edge, BUSY=0, no DONE; a same-cycle GO is ignored.
- RN pulsed low asynchronously mid-WAIT (between edges): EN, BUSY and DONE go to 0 immediately; after release a fresh GO with REQ=1000 yields a single toggle and DONE.
